// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types and default sizes for the data-memory arbiter.
//   arb_state_e : S_CPU gives the CPU port priority; S_DMA is the one-cycle forced DMA slot
//   grant_e     : which port owns the memory port this cycle
package dmem_arb_pkg;

    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_STARVE_LIMIT  = 4;

    typedef enum logic {
        S_CPU,
        S_DMA
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_DMA
    } grant_e;

endpackage

// File: rtl/dmem_arb_fsm.sv
// dmem_arb_fsm
// Arbitration state, starvation counter and grant decode for dmem_arbiter.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cpu_req_i    : CPU port request
//   dma_req_i    : DMA port request
//   grant_o      : port granted this cycle (combinational)
module dmem_arb_fsm
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   cpu_req_i,
    input  logic   dma_req_i,
    output grant_e grant_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [CNT_W-1:0] starve_inc;

    assign starve_inc = starve_q + CNT_W'(1);

    // Grant decode and next state. Nothing is granted while reset is held so
    // an access in flight cannot reach the memory. The counter only ever
    // holds values below the limit: the increment that would reach it moves
    // straight to the forced DMA slot instead.
    always_comb begin
        grant_o  = GNT_NONE;
        state_d  = S_CPU;
        starve_d = '0;
        if (rst_n) begin
            case (state_q)
                S_CPU: begin
                    if (cpu_req_i) begin
                        grant_o = GNT_CPU;
                    end else if (dma_req_i) begin
                        grant_o = GNT_DMA;
                    end
                    if (grant_o == GNT_CPU && dma_req_i) begin
                        if (starve_inc == CNT_W'(STARVE_LIMIT)) begin
                            state_d = S_DMA;
                        end else begin
                            starve_d = starve_inc;
                        end
                    end
                end
                S_DMA: begin
                    if (dma_req_i) begin
                        grant_o = GNT_DMA;
                    end else if (cpu_req_i) begin
                        grant_o = GNT_CPU;
                    end
                end
                default: begin
                    grant_o = GNT_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_CPU;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the data memory's single load/store port between the CPU memory
// stage (fixed priority) and a DMA block-transfer port, with a starvation
// guarantee for DMA.
// Ports:
//   clk, rst_n                                   : clock, asynchronous active-low reset
//   cpu_req/we/byte/addr/wdata -> cpu_rdata      : CPU port, zero-latency when granted
//   cpu_stall                                    : CPU request not serviced this cycle
//   dma_req/we/byte/addr/wdata -> dma_ack        : DMA port, request held until ack
//   dma_rvalid, dma_rdata                        : registered DMA load data, one cycle after ack
//   mem_we, mem_addr_mode, mem_a, mem_wd, mem_rd : memory port (mem_rd combinational)
//   err_misalign                                 : sticky misaligned-word flag
// Build option: DMEM_ARB_ALIGN_CHECK_EN enables the misaligned-word check and
// the err_misalign port; without it misaligned accesses pass to memory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic                     cpu_byte,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    input  logic                     dma_req,
    input  logic                     dma_we,
    input  logic                     dma_byte,
    input  logic [ADDRESS_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0]    dma_wdata,
    output logic                     dma_ack,
    output logic                     dma_rvalid,
    output logic [DATA_WIDTH-1:0]    dma_rdata,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    output logic                     err_misalign,
`endif
    output logic                     mem_we,
    output logic                     mem_addr_mode,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    grant_e                  grant;
    logic                    sel_we;
    logic                    sel_byte;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    misalign;
    logic [DATA_WIDTH-1:0]   rd_eff;
    logic                    dma_rd_fire;
    logic                    dma_rvalid_q, dma_rvalid_d;
    logic [DATA_WIDTH-1:0]   dma_rdata_q, dma_rdata_d;

    dmem_arb_fsm #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req_i (cpu_req),
        .dma_req_i (dma_req),
        .grant_o   (grant)
    );

    // Route the granted port onto the memory port; idle port drives zeros.
    always_comb begin
        sel_we    = 1'b0;
        sel_byte  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (grant)
            GNT_CPU: begin
                sel_we    = cpu_we;
                sel_byte  = cpu_byte;
                sel_addr  = cpu_addr;
                sel_wdata = cpu_wdata;
            end
            GNT_DMA: begin
                sel_we    = dma_we;
                sel_byte  = dma_byte;
                sel_addr  = dma_addr;
                sel_wdata = dma_wdata;
            end
            default: begin
                sel_we = 1'b0;
            end
        endcase
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic err_misalign_q;

    // A misaligned word access is still granted, but neither writes memory
    // nor returns memory data.
    assign misalign = (grant != GNT_NONE) && !sel_byte && (sel_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_misalign_q <= 1'b0;
        end else if (misalign) begin
            err_misalign_q <= 1'b1;
        end
    end

    assign err_misalign = err_misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign mem_we        = sel_we & ~misalign & rst_n;
    assign mem_addr_mode = sel_byte;
    assign mem_a         = sel_addr;
    assign mem_wd        = sel_wdata;

    assign rd_eff    = misalign ? '0 : mem_rd;
    assign cpu_rdata = (grant == GNT_CPU) ? rd_eff : '0;
    assign cpu_stall = cpu_req & (grant != GNT_CPU);
    assign dma_ack   = (grant == GNT_DMA);

    // DMA load data is captured at the edge ending the grant cycle and held
    // until the next DMA load; the valid strobe lasts one cycle.
    assign dma_rd_fire  = dma_ack & ~dma_we;
    assign dma_rvalid_d = dma_rd_fire;
    assign dma_rdata_d  = dma_rd_fire ? rd_eff : dma_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign dma_rvalid = dma_rvalid_q;
    assign dma_rdata  = dma_rdata_q;

endmodule
